// File: rtl/timer_sequencer.sv
// Sequences a programmable table of durations into a single-shot cycle timer,
// issuing one start per nonzero entry and waiting for the timer's end pulse.
module timer_sequencer #(
   parameter int DEPTH = 8,
   parameter int IDX_W = 3,
   parameter int N_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_addr_i,
   input  logic [N_W-1:0]   wr_data_i,
   input  logic             go_i,
   input  logic [IDX_W:0]   count_i,
   input  logic             loop_i,
   input  logic             abort_i,
   input  logic             end_i,
   output logic             start_o,
   output logic [N_W-1:0]   n_o,
   output logic             busy_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             done_o
);

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT} state_t;

   localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

   state_t         state;
   logic [IDX_W:0] cnt;
   logic [IDX_W:0] idx;
   logic           loop_flag;
   logic           issued;
   logic [N_W-1:0] table_mem [DEPTH];

   assign busy_o = (state != IDLE);
   assign idx_o  = idx[IDX_W-1:0];

   // Sequencer state, duration table and registered timer controls.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         loop_flag <= 1'b0;
         issued    <= 1'b0;
         start_o   <= 1'b0;
         n_o       <= '0;
         done_o    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            table_mem[i] <= '0;
         end
      end else begin
         done_o <= 1'b0;
         if (state == IDLE && wr_en_i) begin
            table_mem[wr_addr_i] <= wr_data_i;
         end
         // Abort outranks end_i and every FETCH decision; idx and n_o keep their values.
         if (state != IDLE && abort_i) begin
            state   <= IDLE;
            start_o <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (go_i && !abort_i) begin
                     cnt       <= (count_i > DEPTH_C) ? DEPTH_C : count_i;
                     loop_flag <= loop_i;
                     idx       <= '0;
                     issued    <= 1'b0;
                     if (count_i == '0) begin
                        done_o <= 1'b1;
                     end else begin
                        state <= FETCH;
                     end
                  end
               end
               FETCH: begin
                  // A looping pass that issued nothing terminates instead of spinning.
                  if (idx == cnt) begin
                     if (loop_flag && issued) begin
                        idx    <= '0;
                        issued <= 1'b0;
                     end else begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                     end
                  end else if (table_mem[idx[IDX_W-1:0]] == '0) begin
                     idx <= idx + 1'b1;
                  end else begin
                     n_o     <= table_mem[idx[IDX_W-1:0]];
                     start_o <= 1'b1;
                     issued  <= 1'b1;
                     state   <= ISSUE;
                  end
               end
               ISSUE: begin
                  start_o <= 1'b0;
                  state   <= WAIT;
               end
               WAIT: begin
                  if (end_i) begin
                     idx   <= idx + 1'b1;
                     state <= FETCH;
                  end
               end
               default: begin
                  state   <= IDLE;
                  start_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer: a cycle-by-cycle vector table plus
// hand-written runs driven by a small behavioural timer model.
module tb_timer_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        go;
   logic [3:0]  count;
   logic        loop;
   logic        abort;
   logic        end_i;
   logic        start;
   logic [15:0] n;
   logic        busy;
   logic [2:0]  idx;
   logic        done;

   int pass_cnt = 0;
   int total    = 0;
   int seen_n [32];

   timer_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (wr_en),
      .wr_addr_i(wr_addr),
      .wr_data_i(wr_data),
      .go_i     (go),
      .count_i  (count),
      .loop_i   (loop),
      .abort_i  (abort),
      .end_i    (end_i),
      .start_o  (start),
      .n_o      (n),
      .busy_o   (busy),
      .idx_o    (idx),
      .done_o   (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic        go;
      logic [3:0]  cnt;
      logic        lp;
      logic        ab;
      logic        en;
      logic        e_start;
      logic [15:0] e_n;
      logic        e_busy;
      logic [2:0]  e_idx;
      logic        e_done;
   } vec_t;

   vec_t vecs [28];

   function automatic vec_t mk(input int we, input int wa, input int wd, input int g,
                               input int c, input int lp, input int ab, input int en,
                               input int s, input int nn, input int b, input int i, input int d);
      vec_t r;
      r.we = 1'(we); r.wa = 3'(wa); r.wd = 16'(wd); r.go = 1'(g); r.cnt = 4'(c);
      r.lp = 1'(lp); r.ab = 1'(ab); r.en = 1'(en);
      r.e_start = 1'(s); r.e_n = 16'(nn); r.e_busy = 1'(b); r.e_idx = 3'(i); r.e_done = 1'(d);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic write(input int a, input int d);
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 16'(d);
      step();
      wr_en = 1'b0;
   endtask

   // Issue go, then act as the timer: end_i pulses n cycles after each start.
   task automatic run(input logic [3:0] c, input logic lp, input int abort_at,
                      output int ns, output int nd, output bit to);
      int cd;
      bit aborted;
      ns = 0; nd = 0; cd = 0; aborted = 1'b0; to = 1'b1;
      go = 1'b1; count = c; loop = lp;
      step();
      go = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (done) nd++;
         if (nd > 0 || (aborted && !busy)) begin
            to = 1'b0;
            break;
         end
         end_i = 1'b0; abort = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               end_i = 1'b1;
               if (abort_at > 0 && ns == abort_at) begin
                  abort = 1'b1; aborted = 1'b1;
               end
            end
         end
         if (start) begin
            if (ns < 32) seen_n[ns] = int'(n);
            ns++;
            cd = int'(n);
         end
         step();
      end
      end_i = 1'b0; abort = 1'b0;
   endtask

   initial begin
      int ns, nd, extra;
      bit to;
      rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'd0; go = 1'b0;
      count = 4'd0; loop = 1'b0; abort = 1'b0; end_i = 1'b0;
      step(); step();
      check("reset_outputs", {11'd0, start, n, busy, idx, done}, 32'd0);
      rst = 1'b0;

      //            we wa wd go c lp ab en    s  n  b  i  d
      vecs[0]  = mk(1, 0, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 1, 3, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      vecs[2]  = mk(0, 0, 0, 1, 2, 0, 0, 0,   0, 0, 1, 0, 0);
      vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 5, 1, 0, 0);
      vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 5, 1, 0, 0);
      vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 5, 1, 0, 0);
      vecs[6]  = mk(1, 1, 9, 0, 0, 0, 0, 0,   0, 5, 1, 0, 0);
      vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 5, 1, 1, 0);
      vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 3, 1, 1, 0);
      vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 3, 1, 1, 0);
      vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 3, 1, 1, 0);
      vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 3, 1, 2, 0);
      vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 3, 0, 2, 1);
      vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 3, 0, 2, 0);
      vecs[14] = mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 3, 0, 2, 0);
      vecs[15] = mk(1, 1, 0, 0, 0, 0, 0, 0,   0, 3, 0, 2, 0);
      vecs[16] = mk(1, 2, 7, 0, 0, 0, 0, 0,   0, 3, 0, 2, 0);
      vecs[17] = mk(0, 0, 0, 1, 3, 0, 0, 0,   0, 3, 1, 0, 0);
      vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 3, 1, 1, 0);
      vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 3, 1, 2, 0);
      vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 7, 1, 2, 0);
      vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 7, 1, 2, 0);
      vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 7, 1, 3, 0);
      vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 7, 0, 3, 1);
      vecs[24] = mk(0, 0, 0, 1, 0, 0, 0, 0,   0, 7, 0, 0, 1);
      vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 7, 0, 0, 0);
      vecs[26] = mk(0, 0, 0, 1, 3, 0, 1, 0,   0, 7, 0, 0, 0);
      vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 7, 0, 0, 0);

      for (int i = 0; i < 28; i++) begin
         wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
         go = vecs[i].go; count = vecs[i].cnt; loop = vecs[i].lp;
         abort = vecs[i].ab; end_i = vecs[i].en;
         step();
         check($sformatf("vec%0d", i), {10'd0, start, n, busy, idx, done},
               {10'd0, vecs[i].e_start, vecs[i].e_n, vecs[i].e_busy, vecs[i].e_idx, vecs[i].e_done});
      end
      wr_en = 1'b0; go = 1'b0; abort = 1'b0; end_i = 1'b0;

      // count_i above DEPTH is clamped: all 8 entries run in order.
      for (int i = 0; i < 8; i++) write(i, i + 1);
      run(4'd12, 1'b0, 0, ns, nd, to);
      check("clamp_timeout", 32'(to), 32'd0);
      check("clamp_starts", 32'(ns), 32'd8);
      check("clamp_done", 32'(nd), 32'd1);
      for (int i = 0; i < 8; i++) check($sformatf("clamp_n%0d", i), 32'(seen_n[i]), 32'(i + 1));
      check("clamp_idle", 32'(busy), 32'd0);

      // Looping {2,4} aborted on the same edge as the fifth end pulse.
      write(0, 2); write(1, 4);
      run(4'd2, 1'b1, 5, ns, nd, to);
      check("loop_timeout", 32'(to), 32'd0);
      check("loop_starts", 32'(ns), 32'd5);
      check("loop_no_done", 32'(nd), 32'd0);
      for (int i = 0; i < 5; i++) check($sformatf("loop_n%0d", i), 32'(seen_n[i]), (i % 2 == 0) ? 32'd2 : 32'd4);
      check("abort_hold", {12'd0, n, busy, idx}, {12'd0, 16'd2, 1'b0, 3'd0});
      extra = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (start || done || busy) extra++;
      end
      check("abort_quiet", 32'(extra), 32'd0);

      // A looping run over an all-zero table ends after one pass.
      for (int i = 0; i < 8; i++) write(i, 0);
      run(4'd8, 1'b1, 0, ns, nd, to);
      check("zero_loop_timeout", 32'(to), 32'd0);
      check("zero_loop_starts", 32'(ns), 32'd0);
      check("zero_loop_done", 32'(nd), 32'd1);

      // Reset in WAIT clears outputs and the table.
      write(0, 6);
      go = 1'b1; count = 4'd1; loop = 1'b0;
      step();
      go = 1'b0;
      step();
      check("pre_reset_start", {15'd0, start, n}, {15'd0, 1'b1, 16'd6});
      step(); step();
      check("pre_reset_wait", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      check("mid_reset_outputs", {11'd0, start, n, busy, idx, done}, 32'd0);
      rst = 1'b0;
      run(4'd1, 1'b0, 0, ns, nd, to);
      check("post_reset_timeout", 32'(to), 32'd0);
      check("post_reset_starts", 32'(ns), 32'd0);
      check("post_reset_done", 32'(nd), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Upstream controller for the single-shot cycle timer.
- Holds a small programmable table of durations and runs through it in order.
- For each entry: pulses start_o with the duration on n_o, then waits for the timer's one-cycle end pulse before moving to the next entry.
- Supports one-pass and looping runs, skips zero-length entries, and provides abort.

Parameters:
- DEPTH, 8, number of duration table entries.
- IDX_W, 3, index width; DEPTH = 2**IDX_W.
- N_W, 16, duration width; matches the timer's n input.

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, reset; synchronous, active-high.
- wr_en_i, input, 1, table write strobe.
- wr_addr_i, input, IDX_W, table write address.
- wr_data_i, input, N_W, table write data (duration in cycles).
- go_i, input, 1, start a run; sampled in IDLE only.
- count_i, input, IDX_W+1, number of entries in the run; sampled with go_i.
- loop_i, input, 1, repeat the run until abort; sampled with go_i.
- abort_i, input, 1, terminate the run.
- end_i, input, 1, timer end pulse.
- start_o, output, 1, timer start pulse; registered.
- n_o, output, N_W, duration for the timer; registered.
- busy_o, output, 1, high whenever the state is not IDLE.
- idx_o, output, IDX_W, current table index.
- done_o, output, 1, one-cycle pulse when a run completes.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; start_o=0; n_o=0; idx_o=0; done_o=0; busy_o=0; all table entries=0; latched cnt, loop flag and issued flag cleared.
- Table writes: take effect at the clk edge, in IDLE only. Writes in any other state are ignored.
- States: IDLE, FETCH, ISSUE, WAIT.
- IDLE with go_i=1:
  - cnt = min(count_i, DEPTH); loop flag = loop_i; idx=0; issued=0.
  - If cnt==0: done_o=1 on the next cycle and stay in IDLE.
  - Otherwise go to FETCH.
- FETCH with idx==cnt (end of pass):
  - If loop flag=1 and issued=1: idx=0, issued=0, stay in FETCH.
  - Otherwise: done_o=1 next cycle, go to IDLE.
  - Consequence: a looping run over all-zero entries ends after one pass.
- FETCH with table[idx]==0: idx+1, stay in FETCH. One cycle is spent per skipped entry.
- FETCH with table[idx]!=0: n_o=table[idx]; start_o=1; issued=1; go to ISSUE.
- ISSUE: start_o is high for exactly this one cycle. Clear start_o and go to WAIT.
- WAIT:
  - end_i=1: idx+1, go to FETCH.
  - Otherwise hold.
  - There is no timeout.
- end_i outside WAIT is ignored.
- abort_i in a non-IDLE state has priority over end_i and over all FETCH decisions:
  - Next state is IDLE; start_o=0; no done_o pulse.
  - idx_o and n_o hold their last values.
- abort_i in IDLE: no effect, and it blocks go_i in the same cycle.
- n_o holds its last issued value between issues.
- Latencies:
  - go_i at edge T gives start_o high in cycle T+2 when entry 0 is nonzero.
  - end_i at edge E gives the next start_o in cycle E+2, which guarantees the timer is back in its idle state.
- The timer must not be restarted by any other source while busy_o=1.

Test Plan:
- Table {5,3,0,...}, go_i with count_i=2 and loop_i=0 -> start_o pulses with n_o=5; after end_i, start_o pulses with n_o=3; after end_i, done_o is pulsed once and busy_o drops. Verify against the real timer: end pulses arrive 5 and 3 cycles after the respective starts.
- Table {0,0,7}, count_i=3 -> entries 0 and 1 skipped (2 FETCH cycles); a single start_o with n_o=7; done_o after its end_i.
- go_i with count_i=0 -> done_o high in the next cycle, busy_o never asserts, start_o stays 0. go_i with count_i=12 (DEPTH=8) -> 8 entries run.
- Table {2,4}, loop_i=1 -> start sequence 2,4,2,4,...; abort_i asserted in WAIT on the same edge as end_i -> IDLE, no further start_o, no done_o. All-zero table with loop_i=1 -> done_o after one pass.
- Write to addr 1 while busy -> table unchanged; a write after done_o takes effect on the next run. end_i pulses injected in IDLE and ISSUE -> ignored.
- rst asserted mid-WAIT -> all outputs 0 on the next cycle and the table cleared; a subsequent go_i with count_i=1 produces done_o without start_o (entry 0 is zero).
